game_round_ctrl: RTL

Round controller on the far side of the start/finished handshake with the game-flow FSM. Takes the `start` pulse and `is_playing` level, then tracks lives, score, wave and invaders remaining from gameplay event pulses. Runs respawn and wave-clear delays. Raises `finished` when the game ends.

---
 rtl/game_pkg.sv | 35 +++
 rtl/frame_countdown.sv | 42 ++++
 rtl/game_round_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Types and default constants shared by the round controller, the game-flow FSM and the renderer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_RESPAWN,
    ST_WAVE_CLEAR,
    ST_OVER
  } round_state_t;

  localparam int DEF_NUM_LIVES         = 3;
  localparam int DEF_NUM_INVADERS      = 55;
  localparam int DEF_POINTS_PER_KILL   = 10;
  localparam int DEF_RESPAWN_FRAMES    = 120;
  localparam int DEF_WAVE_DELAY_FRAMES = 60;

  localparam int LIVES_W     = 2;
  localparam int SCORE_W     = 16;
  localparam int WAVE_W      = 4;
  localparam int REMAIN_W    = 6;
  localparam int FRAME_CNT_W = 16;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  function automatic logic [SCORE_W-1:0] sat_add_score(
    input logic [SCORE_W-1:0] a,
    input logic [SCORE_W-1:0] b
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable frame-tick down-counter; o_done pulses for one cycle on the tick that reaches zero.
module frame_countdown
  import game_pkg::*;
#(
  parameter int WIDTH = FRAME_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_tick,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;
  logic             r_active;
  logic             r_done;

  // A load wins over a tick in the same cycle and also cancels any stale done pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count  <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_count  <= i_load_value;
        r_active <= (i_load_value != '0);
      end else if (r_active && i_tick) begin
        r_count <= r_count - WIDTH'(1);
        if (r_count == WIDTH'(1)) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: tracks lives, score, wave and invaders left, and runs respawn and wave-clear delays.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LIVES         = DEF_NUM_LIVES,
  parameter int NUM_INVADERS      = DEF_NUM_INVADERS,
  parameter int POINTS_PER_KILL   = DEF_POINTS_PER_KILL,
  parameter int RESPAWN_FRAMES    = DEF_RESPAWN_FRAMES,
  parameter int WAVE_DELAY_FRAMES = DEF_WAVE_DELAY_FRAMES
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_is_playing,
  input  logic                i_frame_tick,
  input  logic                i_player_hit,
  input  logic                i_invader_killed,
  input  logic                i_invaders_landed,
  output logic                o_finished,
  output logic                o_player_active,
  output logic                o_wave_reset,
  output logic [LIVES_W-1:0]  o_lives,
  output logic [SCORE_W-1:0]  o_score,
  output logic [WAVE_W-1:0]   o_wave,
  output logic [REMAIN_W-1:0] o_remaining
);

  localparam logic [LIVES_W-1:0]     LIVES_INIT    = LIVES_W'(NUM_LIVES);
  localparam logic [REMAIN_W-1:0]    INVADERS_INIT = REMAIN_W'(NUM_INVADERS);
  localparam logic [SCORE_W-1:0]     KILL_POINTS   = SCORE_W'(POINTS_PER_KILL);
  localparam logic [FRAME_CNT_W-1:0] RESPAWN_LOAD  = FRAME_CNT_W'(RESPAWN_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] WAVE_LOAD     = FRAME_CNT_W'(WAVE_DELAY_FRAMES);
  localparam logic [WAVE_W-1:0]      WAVE_MAX      = '1;

  round_state_t        r_state;
  logic                r_finished;
  logic                r_player_active;
  logic                r_wave_reset;
  logic [LIVES_W-1:0]  r_lives;
  logic [SCORE_W-1:0]  r_score;
  logic [WAVE_W-1:0]   r_wave;
  logic [REMAIN_W-1:0] r_remaining;

  logic                   w_hit;
  logic                   w_kill;
  logic                   w_landed;
  logic                   w_kill_valid;
  logic                   w_last_life;
  logic                   w_clears_wave;
  logic [REMAIN_W-1:0]    w_remaining_next;
  logic [SCORE_W-1:0]     w_score_next;
  logic                   w_cnt_load;
  logic [FRAME_CNT_W-1:0] w_cnt_value;
  logic                   w_cnt_done;

  assign w_hit            = i_player_hit & i_is_playing;
  assign w_kill           = i_invader_killed & i_is_playing;
  assign w_landed         = i_invaders_landed & i_is_playing;
  assign w_kill_valid     = w_kill & (r_remaining != '0);
  assign w_remaining_next = w_kill_valid ? r_remaining - REMAIN_W'(1) : r_remaining;
  assign w_score_next     = w_kill_valid ? sat_add_score(r_score, KILL_POINTS) : r_score;
  assign w_last_life      = (r_lives == LIVES_W'(1));
  assign w_clears_wave    = (w_remaining_next == '0);

  // The countdown is reloaded on the same edge that enters RESPAWN or WAVE_CLEAR.
  always_comb begin
    w_cnt_load  = 1'b0;
    w_cnt_value = RESPAWN_LOAD;
    case (r_state)
      ST_PLAY: begin
        if (!w_landed) begin
          if (w_hit && !w_last_life) begin
            w_cnt_load  = 1'b1;
            w_cnt_value = RESPAWN_LOAD;
          end else if (!w_hit && w_kill_valid && w_clears_wave) begin
            w_cnt_load  = 1'b1;
            w_cnt_value = WAVE_LOAD;
          end
        end
      end
      ST_RESPAWN: begin
        if (!w_landed && w_cnt_done && w_clears_wave) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = WAVE_LOAD;
        end
      end
      default: ;
    endcase
  end

  frame_countdown #(
    .WIDTH(FRAME_CNT_W)
  ) u_countdown (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_cnt_load),
    .i_load_value(w_cnt_value),
    .i_tick      (i_frame_tick),
    .o_done      (w_cnt_done)
  );

  // In PLAY a kill always scores; landed beats hit, and hit beats a wave-clearing kill.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state         <= ST_IDLE;
      r_finished      <= 1'b0;
      r_player_active <= 1'b0;
      r_wave_reset    <= 1'b0;
      r_lives         <= '0;
      r_score         <= '0;
      r_wave          <= '0;
      r_remaining     <= '0;
    end else begin
      r_wave_reset <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (i_start) begin
            r_state         <= ST_PLAY;
            r_lives         <= LIVES_INIT;
            r_score         <= '0;
            r_wave          <= WAVE_W'(1);
            r_remaining     <= INVADERS_INIT;
            r_finished      <= 1'b0;
            r_player_active <= 1'b1;
            r_wave_reset    <= 1'b1;
          end
        end
        ST_PLAY: begin
          r_score     <= w_score_next;
          r_remaining <= w_remaining_next;
          if (w_landed) begin
            r_state         <= ST_OVER;
            r_finished      <= 1'b1;
            r_player_active <= 1'b0;
          end else if (w_hit) begin
            r_lives         <= r_lives - LIVES_W'(1);
            r_player_active <= 1'b0;
            if (w_last_life) begin
              r_state    <= ST_OVER;
              r_finished <= 1'b1;
            end else begin
              r_state <= ST_RESPAWN;
            end
          end else if (w_kill_valid && w_clears_wave) begin
            r_state <= ST_WAVE_CLEAR;
          end
        end
        ST_RESPAWN: begin
          r_score     <= w_score_next;
          r_remaining <= w_remaining_next;
          if (w_landed) begin
            r_state         <= ST_OVER;
            r_finished      <= 1'b1;
            r_player_active <= 1'b0;
          end else if (w_cnt_done) begin
            r_player_active <= 1'b1;
            r_state         <= w_clears_wave ? ST_WAVE_CLEAR : ST_PLAY;
          end
        end
        ST_WAVE_CLEAR: begin
          if (w_cnt_done) begin
            r_wave       <= (r_wave == WAVE_MAX) ? r_wave : r_wave + WAVE_W'(1);
            r_remaining  <= INVADERS_INIT;
            r_wave_reset <= 1'b1;
            r_state      <= ST_PLAY;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_finished      = r_finished;
  assign o_player_active = r_player_active;
  assign o_wave_reset    = r_wave_reset;
  assign o_lives         = r_lives;
  assign o_score         = r_score;
  assign o_wave          = r_wave;
  assign o_remaining     = r_remaining;

endmodule
